// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit: direct-mapped BTB with 2-bit direction
// counters for IF lookup, EX-stage redirect/flush, sticky halt and mispredict counter.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_next,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_jumpreg,
  input  logic             ex_halt,
  input  logic [31:0]      ex_alu_result,
  input  logic [PC_W-1:0]  ex_pred_next,
  output logic [31:0]      pc_four,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0]  PC_INC   = PC_W'(32'd4);
  localparam logic [PC_W-1:0]  LSB_MASK = {{(PC_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, ex_ctrl, ex_is_jump;
  logic             ex_taken, do_resolve, do_halt, mispredict;
  logic [PC_W-1:0]  ex_target, actual_next;
  logic             unused_s;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) begin
      ctr_step = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      ctr_step = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
  endfunction

  assign unused_s = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign if_hit = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
  assign ex_ctrl    = ex_branch | ex_jump | ex_jumpreg;
  assign ex_is_jump = ex_jump | ex_jumpreg;

  assign pc_four = {{(32-PC_W){1'b0}}, ex_pc} + 32'd4;
  assign halted  = (state_q == ST_HALTED);
  assign mispredict_count = cnt_q;

  // IF-stage lookup against the pre-update BTB contents
  always_comb begin
    pred_taken = if_hit & ctr_q[if_idx][1];
    if (pred_taken) begin
      pred_next = target_q[if_idx];
    end else begin
      pred_next = if_pc + PC_INC;
    end
  end

  // EX-stage resolution of the actual next PC; JALR wins over JAL over branch
  always_comb begin
    ex_target = ex_pc + ex_imm[PC_W-1:0];
    ex_taken  = 1'b0;
    if (ex_jumpreg) begin
      ex_taken  = 1'b1;
      ex_target = ex_alu_result[PC_W-1:0] & LSB_MASK;
    end else if (ex_jump) begin
      ex_taken = 1'b1;
    end else if (ex_branch) begin
      ex_taken = ex_alu_result[0];
    end else begin
      ex_taken = 1'b0;
    end
    actual_next = ex_taken ? ex_target : ex_pc + PC_INC;
    do_halt     = ex_valid & (state_q == ST_RUN) & ex_halt;
    do_resolve  = ex_valid & (state_q == ST_RUN) & ~ex_halt;
    mispredict  = do_resolve & (actual_next != ex_pred_next);
  end

  // FSM next state, redirect outputs, BTB and counter next values
  always_comb begin
    state_d     = state_q;
    halt_pc_d   = halt_pc_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    cnt_d       = (mispredict && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1'b1) : cnt_q;
    redirect    = 1'b0;
    redirect_pc = actual_next;

    case (state_q)
      ST_RUN: begin
        if (do_halt) begin
          state_d     = ST_HALTED;
          halt_pc_d   = ex_pc;
          redirect    = 1'b1;
          redirect_pc = ex_pc;
        end else begin
          redirect = mispredict;
        end
      end
      ST_HALTED: begin
        redirect    = 1'b1;
        redirect_pc = halt_pc_q;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (reset) begin
      redirect = 1'b0;
    end else begin
      redirect = redirect;
    end
    flush = redirect;

    if (do_resolve && ex_ctrl) begin
      if (ex_hit) begin
        target_d[ex_idx] = ex_taken ? ex_target : target_q[ex_idx];
        ctr_d[ex_idx]    = ex_is_jump ? 2'b11 : ctr_step(ctr_q[ex_idx], ex_taken);
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = ex_is_jump ? 2'b11 : 2'b10;
      end else begin
        valid_d[ex_idx] = valid_q[ex_idx];
      end
    end else if (do_resolve && ex_hit) begin
      // a non-control instruction matched the tag: the entry is stale
      valid_d[ex_idx] = 1'b0;
    end else begin
      valid_d[ex_idx] = valid_q[ex_idx];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      halt_pc_q <= {PC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      valid_q   <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {PC_W{1'b0}};
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      state_q   <= state_d;
      halt_pc_q <= halt_pc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit (default params plus a
// CNT_W=2 instance for counter saturation).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  if_pc, ex_pc, ex_pred_next;
  logic        ex_valid, ex_branch, ex_jump, ex_jumpreg, ex_halt;
  logic [31:0] ex_imm, ex_alu_result;

  logic        pred_taken, redirect, flush, halted;
  logic [8:0]  pred_next, redirect_pc;
  logic [31:0] pc_four;
  logic [15:0] cnt;

  logic        pred_taken2, redirect2, flush2, halted2;
  logic [8:0]  pred_next2, redirect_pc2;
  logic [31:0] pc_four2;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken), .pred_next(pred_next),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jumpreg(ex_jumpreg), .ex_halt(ex_halt),
    .ex_alu_result(ex_alu_result), .ex_pred_next(ex_pred_next), .pc_four(pc_four),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .halted(halted),
    .mispredict_count(cnt)
  );

  branch_predict_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken2), .pred_next(pred_next2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jumpreg(ex_jumpreg), .ex_halt(ex_halt),
    .ex_alu_result(ex_alu_result), .ex_pred_next(ex_pred_next), .pc_four(pc_four2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .flush(flush2), .halted(halted2),
    .mispredict_count(cnt2)
  );

  // kind bits: {halt, jalr, jal, branch}
  localparam logic [3:0] K_N  = 4'b0000;
  localparam logic [3:0] K_B  = 4'b0001;
  localparam logic [3:0] K_J  = 4'b0010;
  localparam logic [3:0] K_R  = 4'b0100;
  localparam logic [3:0] K_HB = 4'b1001;

  typedef struct {
    string       nm;
    logic [8:0]  if_pc;
    logic        v;
    logic [8:0]  pc;
    logic [31:0] imm;
    logic [3:0]  kind;
    logic [31:0] alu;
    logic [8:0]  pin;
    logic        e_pt;
    logic [8:0]  e_pn;
    logic        e_rd;
    logic [8:0]  e_rpc;
    logic        e_hl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input logic [8:0] ifp, input logic v,
                              input logic [8:0] pc, input logic [31:0] imm, input logic [3:0] kind,
                              input logic [31:0] alu, input logic [8:0] pin, input logic e_pt,
                              input logic [8:0] e_pn, input logic e_rd, input logic [8:0] e_rpc,
                              input logic e_hl, input logic [15:0] e_cnt);
    vec_t r;
    r.nm = nm; r.if_pc = ifp; r.v = v; r.pc = pc; r.imm = imm; r.kind = kind;
    r.alu = alu; r.pin = pin; r.e_pt = e_pt; r.e_pn = e_pn; r.e_rd = e_rd;
    r.e_rpc = e_rpc; r.e_hl = e_hl; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    if_pc         = x.if_pc;
    ex_valid      = x.v;
    ex_pc         = x.pc;
    ex_imm        = x.imm;
    ex_branch     = x.kind[0];
    ex_jump       = x.kind[1];
    ex_jumpreg    = x.kind[2];
    ex_halt       = x.kind[3];
    ex_alu_result = x.alu;
    ex_pred_next  = x.pin;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    //    name           if_pc  v  ex_pc  imm           kind  alu           pin    pt  pn     rd  rpc    hl cnt
    vt.push_back(mk("cold_bne",    9'h040, 1'b1, 9'h040, 32'h20, K_B, 32'h1, 9'h044, 1'b0, 9'h044, 1'b1, 9'h060, 1'b0, 16'd0));
    vt.push_back(mk("bne_taken2",  9'h040, 1'b1, 9'h040, 32'h20, K_B, 32'h1, 9'h060, 1'b1, 9'h060, 1'b0, 9'h000, 1'b0, 16'd1));
    vt.push_back(mk("bne_nt1",     9'h040, 1'b1, 9'h040, 32'h20, K_B, 32'h0, 9'h060, 1'b1, 9'h060, 1'b1, 9'h044, 1'b0, 16'd1));
    vt.push_back(mk("bne_nt2",     9'h040, 1'b1, 9'h040, 32'h20, K_B, 32'h0, 9'h060, 1'b1, 9'h060, 1'b1, 9'h044, 1'b0, 16'd2));
    vt.push_back(mk("lookup_weak", 9'h040, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b0, 9'h044, 1'b0, 9'h000, 1'b0, 16'd3));
    vt.push_back(mk("jalr_miss",   9'h010, 1'b1, 9'h010, 32'h0,  K_R, 32'h85, 9'h014, 1'b0, 9'h014, 1'b1, 9'h084, 1'b0, 16'd3));
    vt.push_back(mk("jalr_hit",    9'h010, 1'b1, 9'h010, 32'h0,  K_R, 32'h85, 9'h084, 1'b1, 9'h084, 1'b0, 9'h000, 1'b0, 16'd4));
    vt.push_back(mk("retrain",     9'h040, 1'b1, 9'h040, 32'h20, K_B, 32'h1, 9'h044, 1'b0, 9'h044, 1'b1, 9'h060, 1'b0, 16'd4));
    vt.push_back(mk("alias",       9'h040, 1'b1, 9'h040, 32'h0,  K_N, 32'h0, 9'h060, 1'b1, 9'h060, 1'b1, 9'h044, 1'b0, 16'd5));
    vt.push_back(mk("alias_gone",  9'h040, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b0, 9'h044, 1'b0, 9'h000, 1'b0, 16'd6));
    vt.push_back(mk("wrap",        9'h1FC, 1'b1, 9'h1FC, 32'h0,  K_N, 32'h0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 16'd6));
    vt.push_back(mk("jal_replace", 9'h010, 1'b1, 9'h050, 32'hFFFF_FFF0, K_J, 32'h0, 9'h054, 1'b1, 9'h084, 1'b1, 9'h040, 1'b0, 16'd6));
    vt.push_back(mk("old_evicted", 9'h010, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b0, 9'h014, 1'b0, 9'h000, 1'b0, 16'd7));
    vt.push_back(mk("jal_lookup",  9'h050, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b1, 9'h040, 1'b0, 9'h000, 1'b0, 16'd7));
    vt.push_back(mk("halt",        9'h050, 1'b1, 9'h1F0, 32'h20, K_HB, 32'h1, 9'h1F4, 1'b1, 9'h040, 1'b1, 9'h1F0, 1'b0, 16'd7));
    vt.push_back(mk("halt_idle",   9'h050, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b1, 9'h040, 1'b1, 9'h1F0, 1'b1, 16'd7));
    vt.push_back(mk("halt_br",     9'h050, 1'b1, 9'h050, 32'h8,  K_B, 32'h0, 9'h040, 1'b1, 9'h040, 1'b1, 9'h1F0, 1'b1, 16'd7));
    vt.push_back(mk("halt_jalr",   9'h040, 1'b1, 9'h040, 32'h0,  K_R, 32'h100, 9'h044, 1'b0, 9'h044, 1'b1, 9'h1F0, 1'b1, 16'd7));
    vt.push_back(mk("halt_noalloc",9'h040, 1'b0, 9'h000, 32'h0,  K_N, 32'h0, 9'h000, 1'b0, 9'h044, 1'b1, 9'h1F0, 1'b1, 16'd7));

    // reset cycle with a mispredicting branch present: no redirect
    reset = 1'b1;
    drive(vt[0]);
    @(negedge clk);
    chk("reset_cycle.redirect", {31'b0, redirect}, 32'd0);
    chk("reset_cycle.flush", {31'b0, flush}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("after_reset.pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("after_reset.halted", {31'b0, halted}, 32'd0);
    chk("after_reset.count", {16'b0, cnt}, 32'd0);
    chk("after_reset.redirect", {31'b0, redirect}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge clk);
      chk({vt[i].nm, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, vt[i].e_pt});
      chk({vt[i].nm, ".pred_next"}, {23'b0, pred_next}, {23'b0, vt[i].e_pn});
      chk({vt[i].nm, ".redirect"}, {31'b0, redirect}, {31'b0, vt[i].e_rd});
      chk({vt[i].nm, ".flush"}, {31'b0, flush}, {31'b0, vt[i].e_rd});
      if (vt[i].e_rd) chk({vt[i].nm, ".redirect_pc"}, {23'b0, redirect_pc}, {23'b0, vt[i].e_rpc});
      chk({vt[i].nm, ".halted"}, {31'b0, halted}, {31'b0, vt[i].e_hl});
      chk({vt[i].nm, ".count"}, {16'b0, cnt}, {16'b0, vt[i].e_cnt});
      chk({vt[i].nm, ".pc_four"}, pc_four, {23'b0, vt[i].pc} + 32'd4);
      @(posedge clk); #1;
    end

    // wrap: pc_four is 32-bit, not truncated
    ex_pc = 9'h1FC;
    @(negedge clk);
    chk("wrap.pc_four", pc_four, 32'h0000_0200);

    // reset while halted, with a halt still presented
    @(posedge clk); #1;
    reset = 1'b1; ex_valid = 1'b1; ex_halt = 1'b1; ex_pc = 9'h100;
    @(negedge clk);
    chk("halt_reset.redirect", {31'b0, redirect}, 32'd0);
    chk("halt_reset.flush", {31'b0, flush}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ex_valid = 1'b0; ex_halt = 1'b0; if_pc = 9'h050;
    @(negedge clk);
    chk("halt_reset.halted", {31'b0, halted}, 32'd0);
    chk("halt_reset.redirect_after", {31'b0, redirect}, 32'd0);
    chk("halt_reset.count", {16'b0, cnt}, 32'd0);
    chk("halt_reset.btb_cleared", {31'b0, pred_taken}, 32'd0);
    @(posedge clk); #1;

    // saturation: repeated mispredicts from a non-control instruction
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1'b1; ex_pc = 9'h100; ex_imm = 32'h0; ex_branch = 1'b0; ex_jump = 1'b0;
      ex_jumpreg = 1'b0; ex_halt = 1'b0; ex_alu_result = 32'h0; ex_pred_next = 9'h000;
      @(negedge clk);
      chk("sat.redirect_pc", {23'b0, redirect_pc2}, 32'h104);
      @(posedge clk); #1;
      chk("sat.count_w2", {30'b0, cnt2}, {30'b0, sat_exp[i]});
      chk("sat.count_w16", {16'b0, cnt}, i + 1);
    end
    ex_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
